// File: rtl/id_ex_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_ctrl_pipe
//  Purpose  : DEPTH-stage ID/EX control-word pipe with per-stage valid bits,
//             stall, flush and a registered occupancy count.
//  Option   : ID_EX_CTRL_PIPE_STALL_CNT_EN adds a saturating stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_ctrl_pipe #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                stall_cnt
);

    localparam int c_OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_stage [DEPTH];
    logic               r_valid [DEPTH];
    logic [c_OCC_W-1:0] r_occ;
    logic [c_OCC_W-1:0] w_occ_next;

    // A full pipe retires its last stage while loading stage0, so no overflow.
    assign w_occ_next = r_occ + c_OCC_W'(in_valid) - c_OCC_W'(r_valid[DEPTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= NOP_VALUE;
                r_valid[k] <= 1'b0;
            end
            r_occ <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= NOP_VALUE;
                r_valid[k] <= 1'b0;
            end
            r_occ <= '0;
        end else if (!stall) begin
            r_stage[0] <= in_valid ? in : NOP_VALUE;
            r_valid[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
                r_valid[k] <= r_valid[k-1];
            end
            r_occ <= w_occ_next;
        end
    end

    assign out       = r_stage[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign occupancy = r_occ;

`ifdef ID_EX_CTRL_PIPE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturates rather than wraps; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_ctrl_pipe
//  Purpose  : Directed self-checking bench for id_ex_ctrl_pipe (WIDTH=4, DEPTH=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_ctrl_pipe;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in;
    logic [3:0]  out;
    logic        out_valid;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    id_ex_ctrl_pipe #(
        .WIDTH     (4),
        .DEPTH     (2),
        .NOP_VALUE (4'h0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the three pipe outputs, plus the tied-off counter in the default build.
    task automatic chk(input string tag, input logic [3:0] e_out, input logic e_ov, input logic [1:0] e_occ);
        check({tag, ".out"}, {12'h0, out}, {12'h0, e_out});
        check({tag, ".out_valid"}, {15'h0, out_valid}, {15'h0, e_ov});
        check({tag, ".occupancy"}, {14'h0, occupancy}, {14'h0, e_occ});
`ifndef ID_EX_CTRL_PIPE_STALL_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt, 16'h0000);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic [3:0] d);
        stall    = s;
        flush    = f;
        in_valid = v;
        in       = d;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        #12;
        chk("reset", 4'h0, 1'b0, 2'd0);
        check("reset.stall_cnt", stall_cnt, 16'h0000);
        #2 rst = 1'b0;

        // Streaming A, 5, 3 then drain.
        drive(0, 0, 1, 4'hA); tick(); chk("stream.e1", 4'h0, 0, 2'd1);
        drive(0, 0, 1, 4'h5); tick(); chk("stream.e2", 4'hA, 1, 2'd2);
        drive(0, 0, 1, 4'h3); tick(); chk("stream.e3", 4'h5, 1, 2'd2);
        drive(0, 0, 0, 4'hF); tick(); chk("stream.e4", 4'h3, 1, 2'd1);
        drive(0, 0, 0, 4'hF); tick(); chk("stream.e5", 4'h0, 0, 2'd0);
        tick();                       chk("stream.empty", 4'h0, 0, 2'd0);

        // Load A, stall three cycles with F offered, then release.
        drive(0, 0, 1, 4'hA); tick(); chk("stall.load", 4'h0, 0, 2'd1);
        drive(1, 0, 1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall.hold", 4'h0, 0, 2'd1);
        end
`ifdef ID_EX_CTRL_PIPE_STALL_CNT_EN
        check("stall.cnt3", stall_cnt, 16'h0003);
`endif
        drive(0, 0, 0, 4'hF); tick(); chk("stall.rel1", 4'hA, 1, 2'd1);
        tick();                       chk("stall.rel2", 4'h0, 0, 2'd0);

        // Full pipe, flush and stall together with 7 offered.
        drive(0, 0, 1, 4'hA); tick(); chk("flush.f1", 4'h0, 0, 2'd1);
        drive(0, 0, 1, 4'h5); tick(); chk("flush.f2", 4'hA, 1, 2'd2);
        drive(1, 1, 1, 4'h7); tick(); chk("flush.edge", 4'h0, 0, 2'd0);
`ifdef ID_EX_CTRL_PIPE_STALL_CNT_EN
        check("flush.cnt", stall_cnt, 16'h0003);
`endif
        drive(0, 0, 0, 4'h7); tick(); chk("flush.after1", 4'h0, 0, 2'd0);
        tick();                       chk("flush.after2", 4'h0, 0, 2'd0);

        // Full pipe, asynchronous reset between edges.
        drive(0, 0, 1, 4'hA); tick(); chk("arst.f1", 4'h0, 0, 2'd1);
        drive(0, 0, 1, 4'h5); tick(); chk("arst.f2", 4'hA, 1, 2'd2);
        #2 rst = 1'b1;
        #1 chk("arst.async", 4'h0, 0, 2'd0);
        check("arst.stall_cnt", stall_cnt, 16'h0000);
        #1 rst = 1'b0;
        drive(0, 0, 1, 4'h3); tick(); chk("arst.r1", 4'h0, 0, 2'd1);
        drive(0, 0, 0, 4'h3); tick(); chk("arst.r2", 4'h3, 1, 2'd1);
        tick();                       chk("arst.r3", 4'h0, 0, 2'd0);

        // Alternating valid with 9 held on the input.
        drive(0, 0, 1, 4'h9); tick(); chk("alt.fill", 4'h0, 0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 4'h9); tick(); chk("alt.odd", 4'h9, 1, 2'd1);
            drive(0, 0, 1, 4'h9); tick(); chk("alt.even", 4'h0, 0, 2'd1);
        end
        drive(0, 0, 0, 4'h9); tick(); tick(); chk("alt.drain", 4'h0, 0, 2'd0);

`ifdef ID_EX_CTRL_PIPE_STALL_CNT_EN
        // Saturation, flush-immunity and reset of the stall counter.
        drive(1, 0, 0, 4'h0);
        repeat (70000) @(posedge clk);
        #1 check("cnt.sat", stall_cnt, 16'hFFFF);
        drive(1, 1, 0, 4'h0); tick();
        check("cnt.flush", stall_cnt, 16'hFFFF);
        drive(0, 0, 0, 4'h0);
        #1 rst = 1'b1;
        #1 check("cnt.rst", stall_cnt, 16'h0000);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
